periph_hs_rx: RTL and testbench
===============================

Name: periph_hs_rx

Overview:
Parametrised peripheral receive endpoint for the four-phase send/ack handshake used by the processor's peripheral links.
- Accepts one word of width DATA_W per handshake.
- Stores accepted words in a DEPTH-entry FIFO.
- Presents stored words to the core through a valid/ready interface.
- Applies backpressure by withholding ack while the FIFO is full.

Parameters:
DATA_W, 16, width of the dado word and of each FIFO entry
DEPTH, 4, FIFO entries; power of two, at least 2
TIMEOUT, 255, max cycles ack may stay high waiting for send to drop (used only with HS_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
dado  input  DATA_W  data word from the sender, valid while send=1
send  input  1  sender request, level signal, four-phase protocol
ack  output  1  acknowledge to the sender
out_data  output  DATA_W  FIFO head word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer pops the head when out_valid and out_ready are both 1
count  output  $clog2(DEPTH+1)  current FIFO occupancy
full  output  1  count==DEPTH
err  output  1  sticky handshake timeout flag (held 0 when HS_TIMEOUT_EN is absent)

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state=IDLE; ack=0; count=0; out_valid=0; out_data=0; full=0; err=0.
  - FIFO read/write pointers cleared.
  - Reset mid-handshake drops ack immediately; sender re-requests.
- FSM, 2 states; ack is a Moore output, ack=1 iff state==ACK:
  - IDLE: if send=1 and full=0 at the edge, write dado into the FIFO at that edge and go to ACK. If send=1 and full=1, stay in IDLE with no write.
  - ACK: if send=0, go to IDLE. Otherwise stay in ACK; no further writes regardless of dado.
- Latency: send sampled high at edge N (FIFO not full) -> word written and ack=1 after edge N. Word is visible on out_data/out_valid after edge N when the FIFO was empty.
- Exactly one write per handshake. A new word requires send to go low and then high again.
- FIFO:
  - First-in first-out; out_data = entry at the read pointer, combinational from storage.
  - Pop when out_valid and out_ready at the edge.
  - Pointers wrap modulo DEPTH.
  - out_ready while empty is ignored; count never underflows.
- Simultaneous events:
  - Write and pop in the same cycle: count unchanged, both pointers advance.
  - Full with pop and send in the same cycle: write blocked, because full is evaluated on pre-edge count. Write occurs the next cycle.
- full and count are registered and update at the same edge as the push/pop.
- out_data when out_valid=0 holds the last storage value; bench must not check it.

Optional Feature:
HS_TIMEOUT_EN
- With the macro defined:
  - An internal counter of $clog2(TIMEOUT+1) bits clears on entry to ACK and increments each cycle in ACK with send=1.
  - When the counter reaches TIMEOUT: err is set (sticky until rst), FSM forced to IDLE, ack drops.
  - Returning to IDLE this way does not re-trigger a write while send stays high. An internal lockout stays set until send is seen low.
- Without the macro: no counter, no lockout; err tied to 0; ACK held indefinitely until send=0.

Test Plan:
- Reset then idle: rst=1 mid-run with ack=1 -> ack, count, out_valid, err all 0 immediately, before the next clk edge.
- Single transfer: dado=16'hA5A5, send=1 -> ack=1 after 1 edge, out_valid=1, out_data=16'hA5A5, count=1. Drop send -> ack=0 next edge. Pop -> count=0.
- Fill and backpressure (DEPTH=4, out_ready=0):
  - Four handshakes with 1,2,3,4 -> full=1, count=4.
  - Fifth send=1 -> ack stays 0.
  - Assert out_ready for one cycle -> fifth word accepted after one extra cycle; pop order 2,3,4,5 after draining 1.
- Held send: send kept high 10 cycles with changing dado -> exactly one word written (value at the first edge); ack high throughout.
- Concurrent push/pop: count=2, a handshake write and a pop in the same edge -> count stays 2, FIFO order preserved across pointer wrap.
- HS_TIMEOUT_EN, TIMEOUT=8: send held high -> ack falls and err=1 after 8 cycles in ACK, no second write. send low then high -> normal handshake resumes with err still 1.

Source files
------------

// File: rtl/periph_hs_rx.sv
// Four-phase send/ack receive endpoint feeding a DEPTH-entry FIFO with a valid/ready output.
// Optional handshake timeout (sticky err, forced release of ack) enabled by `define HS_TIMEOUT_EN.
module periph_hs_rx #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_W-1:0]          dado,
  input  logic                       send,
  output logic                       ack,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt_nxt;
  logic              push, pop;
  logic              tmo, lock;

`ifdef HS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] tcnt;

  // The edge that would bring the counter to TIMEOUT forces the release instead.
  assign tmo = (state == ACK) && send && (tcnt == TW'(TIMEOUT-1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
      lock <= 1'b0;
      err  <= 1'b0;
    end else begin
      if (state == IDLE)
        tcnt <= '0;
      else if (send)
        tcnt <= tcnt + TW'(1);
      if (tmo) begin
        err  <= 1'b1;
        lock <= 1'b1;
      end else if (!send) begin
        lock <= 1'b0;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
  assign tmo  = 1'b0;
  assign lock = 1'b0;
  assign err  = 1'b0;
`endif

  assign ack       = (state == ACK);
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid && out_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (send && !full && !lock) begin
        push      = 1'b1;
        state_nxt = ACK;
      end
      ACK:  if (!send || tmo) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = count;
    if (push && !pop)
      cnt_nxt = count + CW'(1);
    else if (!push && pop)
      cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= cnt_nxt;
      full  <= (cnt_nxt == CW'(DEPTH));
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Storage is cleared on reset so out_data reads zero until the first write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= dado;
    end
  end

endmodule

// File: tb/tb_periph_hs_rx.sv
// Bench for periph_hs_rx: directed steps plus random traffic against a queue-based handshake model.
module tb_periph_hs_rx;
  localparam int DATA_W  = 16;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;
  localparam int CW      = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst, send, out_ready;
  logic [DATA_W-1:0] dado, out_data;
  logic              ack, out_valid, full, err;
  logic [CW-1:0]     count;

  always #5 clk = ~clk;

  periph_hs_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .dado(dado), .send(send), .ack(ack),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .err(err)
  );

  int tests = 0;
  int fails = 0;

  // Reference: queue of stored words, plus "handshake in progress", lockout and error flags.
  logic [DATA_W-1:0] q[$];
  bit mack = 0, mlock = 0, merr = 0;
  int mt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    check("ack", 32'(ack), 32'(mack));
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check("err", 32'(err), 32'(merr));
    if (q.size() > 0) check("out_data", 32'(out_data), 32'(q[0]));
  endtask

  // One clock edge of the handshake rules, using the inputs held before the edge.
  task automatic model_edge();
    bit was_full, do_pop;
    was_full = (q.size() == DEPTH);
    do_pop   = (q.size() > 0) && out_ready;
    if (do_pop) void'(q.pop_front());
    if (mack) begin
      if (!send) mack = 0;
`ifdef HS_TIMEOUT_EN
      else begin
        mt++;
        if (mt == TIMEOUT) begin
          mack  = 0;
          merr  = 1;
          mlock = 1;
        end
      end
`endif
    end else if (send && !was_full && !mlock) begin
      q.push_back(dado);
      mack = 1;
      mt   = 0;
    end
    if (!send) mlock = 0;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic handshake(input logic [DATA_W-1:0] d);
    dado = d;
    send = 1'b1;
    cycle();
    send = 1'b0;
    cycle();
  endtask

  initial begin
    logic [DATA_W-1:0] first;
    rst = 1'b1; send = 1'b0; out_ready = 1'b0; dado = '0;
    #1;
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Single transfer
    dado = 16'hA5A5; send = 1'b1;
    cycle();
    check("single_ack", 32'(ack), 32'd1);
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data", 32'(out_data), 32'hA5A5);
    check("single_count", 32'(count), 32'd1);
    send = 1'b0;
    cycle();
    check("single_ackdrop", 32'(ack), 32'd0);
    out_ready = 1'b1;
    cycle();
    check("single_pop", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) handshake(DATA_W'(i));
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    dado = 16'd5; send = 1'b1;
    cycle();
    check("bp_ack0", 32'(ack), 32'd0);
    cycle();
    check("bp_ack1", 32'(ack), 32'd0);
    out_ready = 1'b1;
    cycle();
    check("bp_popcycle_ack", 32'(ack), 32'd0);
    check("bp_popcycle_count", 32'(count), 32'd3);
    out_ready = 1'b0;
    cycle();
    check("bp_accept_ack", 32'(ack), 32'd1);
    check("bp_accept_count", 32'(count), 32'd4);
    send = 1'b0;
    cycle();
    out_ready = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      check("drain_order", 32'(out_data), 32'(v));
      cycle();
    end
    check("drain_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // Held send with changing data
    first = DATA_W'($urandom);
    dado = first; send = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("held_ack", 32'(ack), 32'd1);
      dado = DATA_W'($urandom);
    end
    send = 1'b0;
    cycle();
    check("held_count", 32'(count), 32'd1);
    check("held_data", 32'(out_data), 32'(first));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    // Concurrent push and pop across pointer wrap
    handshake(DATA_W'($urandom));
    handshake(DATA_W'($urandom));
    for (int i = 0; i < 6; i++) begin
      dado = DATA_W'($urandom); send = 1'b1; out_ready = 1'b1;
      cycle();
      check("pushpop_count", 32'(count), 32'd2);
      send = 1'b0; out_ready = 1'b0;
      cycle();
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      dado      = DATA_W'($urandom);
      send      = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) == 0);
      cycle();
    end

    // Reset in the middle of a handshake
    send = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 2) cycle();
    out_ready = 1'b0; dado = 16'h1234; send = 1'b1;
    cycle();
    check("midrst_pre_ack", 32'(ack), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_ack", 32'(ack), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    q.delete(); mack = 0; mlock = 0; merr = 0; mt = 0;
    send = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    handshake(16'hBEEF);
    check("postrst_count", 32'(count), 32'd1);

`ifdef HS_TIMEOUT_EN
    out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    out_ready = 1'b0;
    dado = 16'h0C0C; send = 1'b1;
    cycle();
    for (int i = 1; i < TIMEOUT; i++) begin
      cycle();
      check("tmo_ack_held", 32'(ack), 32'd1);
    end
    cycle();
    check("tmo_ack_drop", 32'(ack), 32'd0);
    check("tmo_err", 32'(err), 32'd1);
    repeat (4) cycle();
    check("tmo_no_rewrite", 32'(count), 32'd1);
    send = 1'b0;
    cycle();
    send = 1'b1; dado = 16'h0D0D;
    cycle();
    check("tmo_resume_ack", 32'(ack), 32'd1);
    check("tmo_resume_count", 32'(count), 32'd2);
    check("tmo_err_sticky", 32'(err), 32'd1);
    send = 1'b0;
    cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
